fifo_rr_drain_arb: RTL and testbench

Round-robin drain arbiter that shares one downstream consumer among N_SRC source FIFOs. Each source is a show-ahead FIFO whose head word is visible while its empty flag is low, and which is popped by a one-cycle read-enable. The block grants one source at a time and drains it for a burst of up to BURST_MAX words. It presents those words on a single valid/ready output stream tagged with the source index, and never pops an empty source.

---
 rtl/fifo_rr_drain_arb.sv | 119 +++++++++++
 tb/tb_fifo_rr_drain_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain arbiter: grants one show-ahead source FIFO at a time and
// streams up to BURST_MAX of its words onto a single valid/ready output.
module fifo_rr_drain_arb #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4,
    localparam int SRC_W     = $clog2(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    input  logic [N_SRC-1:0]            src_empty_i,
    input  logic [N_SRC*DATA_WIDTH-1:0] src_rdata_i,
    output logic [N_SRC-1:0]            src_rden_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_WIDTH-1:0]       out_data_o,
    output logic [SRC_W-1:0]            out_src_o,
    output logic                        out_last_o,
    output logic                        busy_o
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   sel_q, sel_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] words [N_SRC];
    logic                  found;
    logic [SRC_W-1:0]      winner;
    logic [SRC_W-1:0]      idx;
    logic [SRC_W-1:0]      sel_next;
    logic                  head_empty;
    logic                  last_hit;
    logic                  xfer;

    for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
        assign words[k] = src_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // First non-empty source at or after rr_ptr, wrapping at N_SRC.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            idx = SRC_W'((32'(rr_ptr_q) + i) % N_SRC);
            if (!found && !src_empty_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign head_empty = src_empty_i[sel_q];
    assign last_hit   = (cnt_q == CNT_W'(BURST_MAX - 1));
    assign xfer       = out_valid_o && out_ready_i;
    assign sel_next   = (sel_q == SRC_W'(N_SRC - 1)) ? '0 : sel_q + SRC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i && found) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_hit) begin
                        state_d  = IDLE;
                        rr_ptr_d = sel_next;
                    end
                end else if (head_empty) begin
                    state_d  = IDLE;
                    rr_ptr_d = sel_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == GRANT);
        out_valid_o = busy_o && !head_empty;
        out_src_o   = sel_q;
        out_data_o  = words[sel_q];
        out_last_o  = out_valid_o && last_hit;
        src_rden_o  = '0;
        if (out_valid_o && out_ready_i) begin
            src_rden_o[sel_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Directed bench for fifo_rr_drain_arb with a behavioural model of four
// show-ahead source FIFOs that pop on the DUT's read-enables.
module tb_fifo_rr_drain_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BM = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [N-1:0]      src_empty;
    logic [N*DW-1:0]   src_rdata;
    logic [N-1:0]      src_rden;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              out_last;
    logic              busy;

    logic [31:0] mem [N][32];
    int          rp [N];
    int          wp [N];
    int          checks   = 0;
    int          failures = 0;

    fifo_rr_drain_arb #(
        .N_SRC      (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .src_empty_i (src_empty),
        .src_rdata_i (src_rdata),
        .src_rden_o  (src_rden),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Empty sources present a recognisable filler word on their head.
    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            src_empty[k] = (rp[k] == wp[k]);
            src_rdata[k*DW +: DW] = src_empty[k] ? (32'hDEAD_0000 | 32'(k)) : mem[k][rp[k]];
        end
    endtask

    task automatic push(input int k, input logic [31:0] d);
        mem[k][wp[k]] = d;
        wp[k]++;
        refresh();
    endtask

    task automatic tick();
        logic [N-1:0] rs;
        @(negedge clk);
        rs = src_rden;
        if (rs != '0) begin
            check("rden_onehot", 64'($onehot(rs)), 64'd1);
            for (int k = 0; k < N; k++)
                if (rs[k]) check("rden_nonempty", 64'(src_empty[k]), 64'd0);
        end
        @(posedge clk);
        for (int k = 0; k < N; k++)
            if (rs[k]) rp[k]++;
        #1;
        refresh();
        #1;
    endtask

    task automatic expect_out(input string tag, input logic b, input logic v,
                              input logic [1:0] s, input logic [31:0] d, input logic l);
        check({tag, ".busy"},  64'(busy), 64'(b));
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        if (v) begin
            check({tag, ".src"},  64'(out_src), 64'(s));
            check({tag, ".data"}, 64'(out_data), 64'(d));
        end
        check({tag, ".last"}, 64'(out_last), 64'(l));
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rp[k] = 0;
            wp[k] = 0;
        end
        rst_n     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        refresh();
        #2;
        expect_idle("reset");
        check("reset.rden", 64'(src_rden), 64'd0);
        check("reset.src",  64'(out_src), 64'd0);
        check("reset.data", 64'(out_data), 64'hDEAD_0000);

        // Single source 2, six words.
        for (int i = 0; i < 6; i++) push(2, 32'hA0 + 32'(i));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); expect_out("s1_a0", 1, 1, 2, 32'hA0, 0);
        tick(); expect_out("s1_a1", 1, 1, 2, 32'hA1, 0);
        tick(); expect_out("s1_a2", 1, 1, 2, 32'hA2, 0);
        tick(); expect_out("s1_a3", 1, 1, 2, 32'hA3, 1);
        tick(); expect_idle("s1_gap");
        tick(); expect_out("s1_a4", 1, 1, 2, 32'hA4, 0);
        tick(); expect_out("s1_a5", 1, 1, 2, 32'hA5, 0);
        tick(); expect_out("s1_drain", 1, 0, 2, 32'h0, 0);
        tick(); expect_idle("s1_end");

        // rr_ptr is now 3: source 3 must win over source 1.
        push(1, 32'hB0); push(1, 32'hB1); push(3, 32'hC0);
        tick(); expect_out("wrap_c0", 1, 1, 3, 32'hC0, 0);
        tick(); expect_out("wrap_c_drain", 1, 0, 3, 32'h0, 0);
        tick(); expect_idle("wrap_idle0");
        tick(); expect_out("wrap_b0", 1, 1, 1, 32'hB0, 0);
        tick(); expect_out("wrap_b1", 1, 1, 1, 32'hB1, 0);
        tick(); expect_out("wrap_b_drain", 1, 0, 1, 32'h0, 0);
        tick(); expect_idle("wrap_idle1");

        // All sources full, arbitration restarts from 0 after reset.
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 8; i++) push(k, (32'(k) << 8) | 32'(i));
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < BM; w++) begin
                tick();
                expect_out("rr_word", 1, 1, 2'(b % N),
                           (32'(b % N) << 8) | 32'((b / N) * BM + w), (w == BM - 1));
            end
            tick(); expect_idle("rr_gap");
        end

        // Back-pressure on source 1 (words 4..7).
        tick(); expect_out("bp_w4", 1, 1, 1, 32'h104, 0);
        tick(); expect_out("bp_w5", 1, 1, 1, 32'h105, 0);
        out_ready = 1'b0;
        #1; check("bp_rden_stall", 64'(src_rden), 64'd0);
        tick(); expect_out("bp_hold0", 1, 1, 1, 32'h105, 0);
        tick(); expect_out("bp_hold1", 1, 1, 1, 32'h105, 0);
        out_ready = 1'b1;
        tick(); expect_out("bp_w6", 1, 1, 1, 32'h106, 0);
        tick(); expect_out("bp_w7", 1, 1, 1, 32'h107, 1);
        out_ready = 1'b0;
        tick(); expect_out("bp_hold_last", 1, 1, 1, 32'h107, 1);
        out_ready = 1'b1;
        tick(); expect_idle("bp_end");

        // enable dropped mid-burst on source 2.
        tick(); expect_out("en_w4", 1, 1, 2, 32'h204, 0);
        enable = 1'b0;
        tick(); expect_out("en_w5", 1, 1, 2, 32'h205, 0);
        tick(); expect_out("en_w6", 1, 1, 2, 32'h206, 0);
        tick(); expect_out("en_w7", 1, 1, 2, 32'h207, 1);
        tick(); expect_idle("en_off0");
        tick(); expect_idle("en_off1");
        tick(); expect_idle("en_off2");
        enable = 1'b1;
        tick(); expect_out("en_resume", 1, 1, 3, 32'h304, 0);

        // Asynchronous reset during a valid grant.
        rst_n = 1'b0;
        #1;
        expect_idle("rst_mid");
        check("rst_mid.rden", 64'(src_rden), 64'd0);
        check("rst_mid.src",  64'(out_src), 64'd0);
        check("rst_mid.data", 64'(out_data), 64'hDEAD_0000);
        push(0, 32'hD0);
        tick(); expect_idle("rst_hold");
        rst_n = 1'b1;
        tick(); expect_out("rst_d0", 1, 1, 0, 32'hD0, 0);
        tick(); expect_out("rst_d_drain", 1, 0, 0, 32'h0, 0);
        tick(); expect_idle("rst_idle");
        for (int w = 0; w < BM; w++) begin
            tick();
            expect_out("rst_src3", 1, 1, 3, 32'h304 + 32'(w), (w == BM - 1));
        end
        tick(); expect_idle("rst_end");
        check("rst_src3_empty", 64'(src_empty[3]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
